// File: rtl/exe_div_ctrl_pkg.sv
// Shared definitions for the EXE-stage divider sequencer: state encodings
// and default sizing.
package exe_div_ctrl_pkg;

  localparam int DIV_WIDTH_DEF  = 32;
  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/exe_div_ctrl_iter.sv
// div_iter: one radix-2 restoring division step, purely combinational.
// {rem,quo} shifts left by one; if the widened partial remainder is at least
// the divisor it is reduced and a 1 enters the quotient LSB.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           ge;

  // Compare is WIDTH+1 bits wide; the difference always fits in WIDTH bits
  // because the partial remainder entering a step is below the divisor.
  // With a zero divisor every step subtracts nothing, which yields an
  // all-ones quotient and returns the dividend as remainder.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    rem_out = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: sequencer for the multi-cycle integer divider in EXE.
// Captures magnitudes and sign information, iterates one quotient bit per
// cycle, then holds es_ready_go high in DONE until MEM accepts.
//
// state    | meaning
// ---------+---------------------------------------------------------
// DIV_IDLE | no divide in flight; captures a new div from EXE
// DIV_BUSY | restoring iterations running, EXE stalled
// DIV_DONE | div_result valid, waiting for MEM to accept
import exe_div_ctrl_pkg::*;

module exe_div_ctrl #(
  parameter int WIDTH      = DIV_WIDTH_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             es_valid,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic             div_rem,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             ms_allow_in,
  input  logic             flush,
  output logic             es_ready_go,
  output logic [WIDTH-1:0] div_result,
  output logic             div_busy
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    iter_cnt;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             rem_sel_q;

  logic             div_here;
  logic             start;
  logic             last_step;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_abs;
  logic [WIDTH-1:0] src2_abs;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Handshake, operand magnitude and sign-correction helpers.
  always_comb begin
    div_here    = es_valid && div_req;
    start       = (state_q == DIV_IDLE) && div_here && !flush;
    last_step   = (state_q == DIV_BUSY) && (iter_cnt == LAST_ITER);
    es_ready_go = !div_here || (state_q == DIV_DONE);
    div_busy    = (state_q != DIV_IDLE);
    src1_neg    = div_signed && div_src1[WIDTH-1];
    src2_neg    = div_signed && div_src2[WIDTH-1];
    src1_abs    = src1_neg ? -div_src1 : div_src1;
    src2_abs    = src2_neg ? -div_src2 : div_src2;
    quo_fix     = quo_neg_q ? -step_quo : step_quo;
    rem_fix     = rem_neg_q ? -step_rem : step_rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (div_here)    state_d = DIV_BUSY;
      DIV_BUSY: if (last_step)   state_d = DIV_DONE;
      DIV_DONE: if (ms_allow_in) state_d = DIV_IDLE;
      default:                   state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  // Operand capture, iteration and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt   <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      div_result <= '0;
    end else if (flush) begin
      iter_cnt <= '0;
    end else if (start) begin
      iter_cnt  <= '0;
      divisor_q <= src2_abs;
      rem_q     <= '0;
      quo_q     <= src1_abs;
      quo_neg_q <= src1_neg ^ src2_neg;
      rem_neg_q <= src1_neg;
      rem_sel_q <= div_rem;
    end else if (state_q == DIV_BUSY) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      if (last_step) begin
        iter_cnt   <= '0;
        div_result <= rem_sel_q ? rem_fix : quo_fix;
      end else begin
        iter_cnt <= iter_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl: directed table, multi-cycle corner
// sequences and randomized divides against an arithmetic reference model.
module tb_exe_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        es_valid;
  logic        div_req;
  logic        div_signed;
  logic        div_rem;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        ms_allow_in;
  logic        flush;
  logic        es_ready_go;
  logic [31:0] div_result;
  logic        div_busy;

  int checks   = 0;
  int failures = 0;

  exe_div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .es_valid    (es_valid),
    .div_req     (div_req),
    .div_signed  (div_signed),
    .div_rem     (div_rem),
    .div_src1    (div_src1),
    .div_src2    (div_src2),
    .ms_allow_in (ms_allow_in),
    .flush       (flush),
    .es_ready_go (es_ready_go),
    .div_result  (div_result),
    .div_busy    (div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          sgn;
    bit          rem;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Integer arithmetic reference: truncating division, remainder takes the
  // dividend's sign; divide by zero gives all-ones magnitude and remainder=a.
  function automatic logic [31:0] ref_div(input bit sgn, input bit rem,
                                          input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) begin
      q = (sgn && a[31]) ? 64'd1 : 64'h0000_0000_FFFF_FFFF;
      r = longint'({32'd0, a});
    end else begin
      if (sgn) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      q = na / nb;
      r = na % nb;
    end
    return rem ? r[31:0] : q[31:0];
  endfunction

  // Issue one divide from IDLE, measure latency, optionally stall in DONE,
  // then hand off. Inputs stay asserted after handoff; callers decide.
  task automatic run_div(input string nm, input bit sgn, input bit rem,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input bit scramble);
    int lat;
    es_valid = 1'b1; div_req = 1'b1; div_signed = sgn; div_rem = rem;
    div_src1 = a; div_src2 = b; ms_allow_in = 1'b0;
    #1;
    check({nm, "_stall_t0"}, 32'(es_ready_go), 32'd0);
    lat = 0;
    while (!es_ready_go && lat < 40) begin
      step();
      lat++;
      if (scramble) begin
        div_src1 = $urandom;
        div_src2 = $urandom;
        #1;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'd33);
    check({nm, "_result"}, div_result, exp);
    for (int k = 0; k < hold; k++) begin
      step();
      check({nm, "_hold_result"}, div_result, exp);
      check({nm, "_hold_ready"}, 32'(es_ready_go), 32'd1);
      check({nm, "_hold_busy"}, 32'(div_busy), 32'd1);
    end
    ms_allow_in = 1'b1;
    step();
    ms_allow_in = 1'b0;
    #1;
    check({nm, "_idle_after"}, 32'(div_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; es_valid = 1'b0; div_req = 1'b0; div_signed = 1'b0; div_rem = 1'b0;
    div_src1 = '0; div_src2 = '0; ms_allow_in = 1'b0; flush = 1'b0;

    vecs.push_back('{"u100_7_q",   1'b0, 1'b0, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{"u100_7_r",   1'b0, 1'b1, 32'd100,        32'd7,          32'd2});
    vecs.push_back('{"s_m7_2_q",   1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{"s_m7_2_r",   1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{"u_fff9_2_q", 1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC});
    vecs.push_back('{"u_x_0_q",    1'b0, 1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"u_x_0_r",    1'b0, 1'b1, 32'h1234_5678,  32'd0,          32'h1234_5678});
    vecs.push_back('{"s_ovf_q",    1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    vecs.push_back('{"s_ovf_r",    1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{"s_7_m2_r",   1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1});

    step(); step();
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_result", div_result, 32'd0);
    check("reset_ready", 32'(es_ready_go), 32'd1);

    // Directed table; operands scrambled while busy to prove single sampling.
    foreach (vecs[i]) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b,
              vecs[i].exp, 0, 1'b1);
      es_valid = 1'b0; div_req = 1'b0;
      step();
    end

    // DONE held with ms_allow_in low for 5 cycles.
    run_div("done_stall", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 5, 1'b0);
    es_valid = 1'b0; div_req = 1'b0;
    step();

    // Back-to-back: second div captured the cycle right after handoff.
    run_div("b2b_first", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 0, 1'b0);
    run_div("b2b_second", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 0, 1'b0);
    es_valid = 1'b0; div_req = 1'b0;
    step();

    // Flush at the 10th BUSY cycle, then an ADD must not stall.
    es_valid = 1'b1; div_req = 1'b1; div_signed = 1'b0; div_rem = 1'b0;
    div_src1 = 32'd1000; div_src2 = 32'd3;
    step();
    for (int k = 0; k < 9; k++) step();
    flush = 1'b1;
    #1;
    check("flush_busy_before", 32'(div_busy), 32'd1);
    step();
    flush = 1'b0; div_req = 1'b0;
    #1;
    check("flush_busy_after", 32'(div_busy), 32'd0);
    check("flush_add_ready", 32'(es_ready_go), 32'd1);
    step();
    check("flush_stays_idle", 32'(div_busy), 32'd0);
    run_div("after_flush", 1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, 0, 1'b0);
    es_valid = 1'b0; div_req = 1'b0;
    step();

    // Flush beats a new capture in IDLE.
    es_valid = 1'b1; div_req = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; es_valid = 1'b0; div_req = 1'b0;
    #1;
    check("flush_beats_capture", 32'(div_busy), 32'd0);
    step();

    // Reset mid-BUSY.
    es_valid = 1'b1; div_req = 1'b1; div_src1 = 32'd50; div_src2 = 32'd5;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; div_req = 1'b0;
    #1;
    check("rst_mid_busy", 32'(div_busy), 32'd0);
    check("rst_mid_result", div_result, 32'd0);
    check("rst_mid_ready", 32'(es_ready_go), 32'd1);
    run_div("after_rst", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 0, 1'b0);
    es_valid = 1'b0; div_req = 1'b0;
    step();

    // Randomized divides against the reference model.
    for (int n = 0; n < 1000; n++) begin
      bit          sgn, rem;
      logic [31:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      rem = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_div("rand", sgn, rem, a, b, ref_div(sgn, rem, a, b), 0, 1'b1);
      es_valid = 1'b0; div_req = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
